// File: rtl/motion_alarm_ctrl.sv
// Motion alarm qualifier: per-camera arm/hold FSMs evaluated at frame boundaries,
// blinking border-overlay enables for the RGB mux, and saturating raise counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no alarm, no motion run in progress
// S_ARM   | counting consecutive motion frames toward ARM_FRAMES
// S_ALARM | alarm asserted, current frame had motion
// S_HOLD  | alarm asserted, counting down motion-free frames
module motion_alarm_ctrl #(
    parameter int ARM_FRAMES   = 3,
    parameter int HOLD_FRAMES  = 8,
    parameter int BLINK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [1:0]  motion_raw,
    input  logic        clr_count,
    output logic [1:0]  alarm,
    output logic [1:0]  overlay_en,
    output logic [1:0]  alarm_rise,
    output logic [15:0] event_count
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ALARM, S_HOLD} state_e;

    localparam logic [3:0] ARM_LAST   = 4'(ARM_FRAMES);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_e     state_q    [2];
    state_e     state_d    [2];
    logic [3:0] arm_cnt_q  [2];
    logic [3:0] arm_cnt_d  [2];
    logic [7:0] hold_cnt_q [2];
    logic [7:0] hold_cnt_d [2];
    logic [7:0] evt_q      [2];
    logic [7:0] evt_d      [2];
    logic [1:0] seen_q, seen_d;
    logic [1:0] alarm_q, alarm_d;
    logic [1:0] rise_q, rise_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_phase_q, blink_phase_d;
    logic [1:0] frame_hit;

    // Per-channel frame qualification, FSM next state and raise counting.
    always_comb begin
        frame_hit = seen_q | motion_raw;
        if (!enable)
            seen_d = 2'b00;
        else if (frame_tick)
            seen_d = 2'b00;
        else
            seen_d = seen_q | motion_raw;

        for (int i = 0; i < 2; i++) begin
            state_d[i]    = state_q[i];
            arm_cnt_d[i]  = arm_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            if (!enable) begin
                state_d[i]    = S_IDLE;
                arm_cnt_d[i]  = 4'd0;
                hold_cnt_d[i] = 8'd0;
            end else if (frame_tick) begin
                case (state_q[i])
                    S_IDLE: begin
                        if (frame_hit[i]) begin
                            if (ARM_FRAMES == 1) begin
                                state_d[i] = S_ALARM;
                            end else begin
                                state_d[i]   = S_ARM;
                                arm_cnt_d[i] = 4'd1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (!frame_hit[i]) begin
                            state_d[i]   = S_IDLE;
                            arm_cnt_d[i] = 4'd0;
                        end else if (arm_cnt_q[i] + 4'd1 == ARM_LAST) begin
                            state_d[i]   = S_ALARM;
                            arm_cnt_d[i] = 4'd0;
                        end else begin
                            arm_cnt_d[i] = arm_cnt_q[i] + 4'd1;
                        end
                    end
                    S_ALARM: begin
                        if (!frame_hit[i]) begin
                            if (HOLD_FRAMES == 0) begin
                                state_d[i] = S_IDLE;
                            end else begin
                                state_d[i]    = S_HOLD;
                                hold_cnt_d[i] = HOLD_LOAD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (frame_hit[i]) begin
                            state_d[i]    = S_ALARM;
                            hold_cnt_d[i] = 8'd0;
                        end else if (hold_cnt_q[i] == 8'd0) begin
                            state_d[i] = S_IDLE;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] - 8'd1;
                        end
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end

            alarm_d[i] = (state_d[i] == S_ALARM) || (state_d[i] == S_HOLD);
            rise_d[i]  = alarm_d[i] & ~alarm_q[i];

            evt_d[i] = evt_q[i];
            if (clr_count)
                evt_d[i] = 8'd0;
            else if (rise_d[i] && (evt_q[i] != 8'hFF))
                evt_d[i] = evt_q[i] + 8'd1;
        end
    end

    // Shared blink timer; parked at visible phase while no channel is alarming.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (alarm_q == 2'b00) begin
            blink_cnt_d   = 8'd0;
            blink_phase_d = 1'b1;
        end else if (enable && frame_tick && (BLINK_FRAMES != 0)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= S_IDLE;
                arm_cnt_q[i]  <= 4'd0;
                hold_cnt_q[i] <= 8'd0;
                evt_q[i]      <= 8'd0;
            end
            seen_q        <= 2'b00;
            alarm_q       <= 2'b00;
            rise_q        <= 2'b00;
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= state_d[i];
                arm_cnt_q[i]  <= arm_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                evt_q[i]      <= evt_d[i];
            end
            seen_q        <= seen_d;
            alarm_q       <= alarm_d;
            rise_q        <= rise_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign alarm       = alarm_q;
    assign overlay_en  = alarm_q & {2{blink_phase_q}};
    assign alarm_rise  = rise_q;
    assign event_count = {evt_q[1], evt_q[0]};

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// Bench for motion_alarm_ctrl: two instances (default parameters, and the
// ARM=1/HOLD=0/BLINK=0 corner) share stimulus and are compared every cycle
// against a run-length behavioural model, plus literal directed expectations.
module tb_motion_alarm_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        enable;
    logic [1:0]  motion_raw;
    logic        clr_count;
    logic [1:0]  a_alarm, a_overlay, a_rise;
    logic [15:0] a_count;
    logic [1:0]  b_alarm, b_overlay, b_rise;
    logic [15:0] b_count;

    int total = 0;
    int bad   = 0;

    // model state, indexed [instance][channel]
    int m_run  [2][2];
    int m_free [2][2];
    int m_cnt  [2][2];
    bit m_alm  [2][2];
    bit m_rise [2][2];
    bit m_seen [2][2];
    int m_n    [2];

    int p_arm   [2] = '{3, 1};
    int p_hold  [2] = '{8, 0};
    int p_blink [2] = '{4, 0};

    always #5 clk = ~clk;

    motion_alarm_ctrl u_dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .motion_raw(motion_raw), .clr_count(clr_count),
        .alarm(a_alarm), .overlay_en(a_overlay), .alarm_rise(a_rise),
        .event_count(a_count)
    );

    motion_alarm_ctrl #(.ARM_FRAMES(1), .HOLD_FRAMES(0), .BLINK_FRAMES(0)) u_dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .motion_raw(motion_raw), .clr_count(clr_count),
        .alarm(b_alarm), .overlay_en(b_overlay), .alarm_rise(b_rise),
        .event_count(b_count)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        for (int ch = 0; ch < 2; ch++) begin
            m_run[d][ch]  = 0;
            m_free[d][ch] = 0;
            m_cnt[d][ch]  = 0;
            m_alm[d][ch]  = 0;
            m_rise[d][ch] = 0;
            m_seen[d][ch] = 0;
        end
        m_n[d] = 0;
    endtask

    // One clock of the behavioural model: motion runs and motion-free runs are
    // counted per channel; the blink phase is derived from ticks seen while alarming.
    task automatic model_step(input int d);
        bit f;
        bit was;
        if (!(m_alm[d][0] || m_alm[d][1]))
            m_n[d] = 0;
        else if (enable && frame_tick)
            m_n[d]++;
        for (int ch = 0; ch < 2; ch++) begin
            was = m_alm[d][ch];
            f   = m_seen[d][ch] | motion_raw[ch];
            if (!enable) begin
                m_run[d][ch]  = 0;
                m_free[d][ch] = 0;
                m_alm[d][ch]  = 0;
                m_seen[d][ch] = 0;
            end else if (frame_tick) begin
                m_seen[d][ch] = 0;
                if (!m_alm[d][ch]) begin
                    if (f) begin
                        m_run[d][ch]++;
                        if (m_run[d][ch] >= p_arm[d]) begin
                            m_alm[d][ch] = 1;
                            m_run[d][ch] = 0;
                        end
                    end else begin
                        m_run[d][ch] = 0;
                    end
                end else if (f) begin
                    m_free[d][ch] = 0;
                end else begin
                    m_free[d][ch]++;
                    if (m_free[d][ch] > p_hold[d]) begin
                        m_alm[d][ch]  = 0;
                        m_free[d][ch] = 0;
                    end
                end
            end else begin
                m_seen[d][ch] = m_seen[d][ch] | motion_raw[ch];
            end
            m_rise[d][ch] = m_alm[d][ch] & ~was;
            if (clr_count)
                m_cnt[d][ch] = 0;
            else if (m_rise[d][ch] && m_cnt[d][ch] < 255)
                m_cnt[d][ch]++;
        end
    endtask

    function automatic logic [1:0] e_alarm(input int d);
        return {m_alm[d][1], m_alm[d][0]};
    endfunction

    function automatic logic [1:0] e_rise(input int d);
        return {m_rise[d][1], m_rise[d][0]};
    endfunction

    function automatic logic [1:0] e_overlay(input int d);
        logic phase;
        phase = (p_blink[d] == 0) ? 1'b1 : (((m_n[d] / p_blink[d]) % 2) == 0);
        return e_alarm(d) & {2{phase}};
    endfunction

    function automatic logic [15:0] e_count(input int d);
        return {8'(m_cnt[d][1]), 8'(m_cnt[d][0])};
    endfunction

    // model update on every active edge or reset
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // compare both instances against the model away from the active edge
    initial forever begin
        @(negedge clk);
        chk("a_alarm",   16'(a_alarm),   16'(e_alarm(0)));
        chk("a_overlay", 16'(a_overlay), 16'(e_overlay(0)));
        chk("a_rise",    16'(a_rise),    16'(e_rise(0)));
        chk("a_count",   a_count,        e_count(0));
        chk("b_alarm",   16'(b_alarm),   16'(e_alarm(1)));
        chk("b_overlay", 16'(b_overlay), 16'(e_overlay(1)));
        chk("b_rise",    16'(b_rise),    16'(e_rise(1)));
        chk("b_count",   b_count,        e_count(1));
    end

    // one-cycle frame_tick with the given motion; returns one step after the edge
    task automatic frame(input logic [1:0] mot, input logic clr);
        frame_tick = 1'b1;
        motion_raw = mot;
        clr_count  = clr;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        motion_raw = 2'b00;
        clr_count  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int mode;
        reset      = 1'b1;
        enable     = 1'b1;
        frame_tick = 1'b0;
        motion_raw = 2'b00;
        clr_count  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_alarm", 16'(a_alarm), 16'h0);
        chk("reset_count", a_count, 16'h0);

        // three consecutive motion frames raise cam1 only
        frame(2'b01, 1'b0); idle(2);
        frame(2'b01, 1'b0); idle(2);
        chk("arm_not_yet", 16'(a_alarm), 16'h0);
        frame(2'b01, 1'b0);
        chk("arm_alarm", 16'(a_alarm), 16'h1);
        chk("arm_rise",  16'(a_rise),  16'h1);
        chk("arm_count", a_count,      16'h0001);
        chk("b_arm1_count", b_count,   16'h0001);
        idle(1);
        chk("rise_single", 16'(a_rise), 16'h0);

        // blink: 4 frames visible, 4 hidden, visible again; BLINK=0 stays on
        for (int k = 1; k <= 8; k++) begin
            frame(2'b01, 1'b0);
            chk("blink_a", 16'(a_overlay), (k < 4 || k == 8) ? 16'h1 : 16'h0);
            chk("blink_b", 16'(b_overlay), 16'h1);
        end

        // hold: alarm survives eight free frames, drops on the ninth
        for (int k = 1; k <= 9; k++) begin
            frame(2'b00, 1'b0);
            if (k == 8) chk("hold_8", 16'(a_alarm), 16'h1);
        end
        chk("hold_drop", 16'(a_alarm), 16'h0);

        // motion during hold returns to alarm without a new raise
        frame(2'b01, 1'b0); frame(2'b01, 1'b0); frame(2'b01, 1'b0);
        chk("rearm_count", a_count, 16'h0002);
        repeat (4) frame(2'b00, 1'b0);
        frame(2'b01, 1'b0);
        chk("hold_back_alarm", 16'(a_alarm), 16'h1);
        chk("hold_back_rise",  16'(a_rise),  16'h0);
        chk("hold_back_count", a_count,      16'h0002);

        // disable while holding, then re-arm from scratch
        frame(2'b00, 1'b0);
        enable = 1'b0;
        idle(1);
        chk("dis_alarm", 16'(a_alarm), 16'h0);
        chk("dis_count", a_count,      16'h0002);
        enable = 1'b1;
        frame(2'b01, 1'b0); frame(2'b01, 1'b0);
        chk("reen_wait", 16'(a_alarm), 16'h0);
        frame(2'b01, 1'b0);
        chk("reen_alarm", 16'(a_alarm), 16'h1);
        chk("reen_count", a_count,      16'h0003);

        // sticky: motion outside the tick cycle still qualifies the frame
        frame(2'b00, 1'b0);
        motion_raw = 2'b10; idle(1); motion_raw = 2'b00; idle(2);
        frame(2'b00, 1'b0);
        frame(2'b10, 1'b0);
        idle(1);
        motion_raw = 2'b10; idle(1); motion_raw = 2'b00;
        frame(2'b00, 1'b0);
        chk("sticky_alarm", 16'(a_alarm[1]), 16'h1);

        // asynchronous reset while holding
        frame(2'b00, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_alarm", 16'(a_alarm), 16'h0);
        chk("rst_count", a_count,      16'h0);
        @(posedge clk); #1 reset = 1'b0;

        // 300 raises with tick-cycle-only motion saturate at 255
        for (int r = 0; r < 300; r++) begin
            repeat (3) frame(2'b01, 1'b0);
            repeat (9) frame(2'b00, 1'b0);
        end
        chk("sat_count", a_count, 16'h00FF);
        frame(2'b01, 1'b0); frame(2'b01, 1'b0); frame(2'b01, 1'b1);
        chk("clr_rise_alarm", 16'(a_alarm), 16'h1);
        chk("clr_rise_count", a_count,      16'h0000);

        // randomized traffic in motion-density phases
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = int'($urandom_range(0, 2));
            frame_tick = ($urandom_range(0, 2) == 0);
            for (int ch = 0; ch < 2; ch++) begin
                case (mode)
                    0:       motion_raw[ch] = ($urandom_range(0, 9) != 0);
                    1:       motion_raw[ch] = ($urandom_range(0, 19) == 0);
                    default: motion_raw[ch] = $urandom_range(0, 1) != 0;
                endcase
            end
            enable    = ($urandom_range(0, 149) != 0);
            clr_count = ($urandom_range(0, 399) == 0);
            reset     = ($urandom_range(0, 1499) == 0);
            @(posedge clk); #1;
        end
        reset      = 1'b0;
        frame_tick = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
